// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx
// Serial UART receiver driven by a 16x-oversample rate tick. The rx line is
// double-flopped, the start bit is confirmed at mid-bit, then each data bit
// is sampled once at its centre and shifted in LSB first. The stop bit is
// checked at its centre, and the byte is then published with a one-cycle strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> an even parity bit follows the data bits; parity_err port present
//   undefined -> plain 8N1, no parity state and no parity_err port
//
// Ports
//   clk           in   1     system clock, rising edge
//   reset         in   1     asynchronous, active-high reset
//   rx            in   1     serial line, idle high, asynchronous to clk
//   rate          in   1     one-clk pulse at 16x baud
//   dout          out  DBIT  last received word, LSB = first bit on line
//   rx_done_tick  out  1     one-clk strobe, dout/frame_err valid in the same cycle
//   frame_err     out  1     stop bit sampled low on the last frame
//   parity_err    out  1     (parity build only) data+parity had an odd count of ones
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rate,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    // Tick counter must reach SB_TICK-1 (31 for two stop bits) as well as 15.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            p_reg, p_next;
    logic            done;
    logic            rx_m, rx_s;

    // Input synchroniser: rx is asynchronous, only rx_s is used below.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // State register plus the registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            p_reg        <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            p_reg        <= p_next;
            rx_done_tick <= done;
            if (done) begin
                // Published even on a framing error so the caller can inspect it.
                dout      <= b_reg;
                frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                parity_err <= (^b_reg) ^ p_reg;
`endif
            end
        end
    end

    // Next-state logic. Nothing moves without a rate tick except start detection.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        p_next     = p_reg;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (rate) begin
                    if (s_reg == SW'(7)) begin
                        // Mid start bit: a line back high was only a glitch.
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            DATA: begin
                if (rate) begin
                    if (s_reg == SW'(15)) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == NW'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (rate) begin
                    if (s_reg == SW'(15)) begin
                        s_next     = '0;
                        p_next     = rx_s;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (rate) begin
                    if (s_reg == SW'(SB_TICK-1)) begin
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: frame completes on the tick that ends the stop bit.
    always_comb begin
        done = 1'b0;
        if (state_reg == STOP && rate && s_reg == SW'(SB_TICK-1))
            done = 1'b1;
    end

endmodule
